// File: rtl/cosim_list_msg_encoder_if.sv
// Byte-stream input and message output channel for cosim_list_msg_encoder.
// The slave modport is the encoder side; master is the producer/endpoint side.
interface cosim_list_msg_encoder_if #(
  parameter int MAX_BYTES = 3
);
  localparam int DATA_WORDS = (MAX_BYTES + 7) / 8;
  localparam int MSG_BITS   = 128 + 64 * DATA_WORDS;

  logic                in_valid;
  logic                in_ready;
  logic [7:0]          in_data;
  logic                in_last;
  logic                msg_valid;
  logic                msg_ready;
  logic [MSG_BITS-1:0] msg_data;

  modport slave  (input  in_valid, in_data, in_last, msg_ready,
                  output in_ready, msg_valid, msg_data);
  modport master (output in_valid, in_data, in_last, msg_ready,
                  input  in_ready, msg_valid, msg_data);
endinterface

// File: rtl/cosim_list_msg_encoder.sv
// Frames a byte stream into one Cap'n Proto message (root ptr, list-of-bytes ptr, payload).
// Define ESI_LIST_ENCODER_STATS_EN to build the msg_count handshake counter.
module cosim_list_msg_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       we,
  input  logic [7:0] d,
  output logic [7:0] q
);
  always_ff @(posedge clk) begin
    if (rst || clr) q <= 8'h00;
    else if (we)    q <= d;
  end
endmodule

module cosim_list_msg_encoder #(
  parameter int MAX_BYTES = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  cosim_list_msg_encoder_if.slave     bus,
  output logic                        overflow,
  output logic [31:0]                 msg_count
);
  localparam int DATA_WORDS = (MAX_BYTES + 7) / 8;
  localparam int MSG_BITS   = 128 + 64 * DATA_WORDS;
  localparam int LANES      = 8 * DATA_WORDS;
  localparam int CW         = $clog2(MAX_BYTES + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_BYTES);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]               state;
  logic [CW-1:0]            count;
  logic                     accept;
  logic                     done;
  logic [LANES-1:0][7:0]    lane_q;
  logic [LANES-1:0]         lane_we;
  logic [63:0]              list_ptr;
  logic [MSG_BITS-1:0]      msg;

  assign accept = bus.in_valid && bus.in_ready;
  assign done   = (state == SEND) && bus.msg_ready;

  assign bus.in_ready  = !rst && (state == FILL);
  assign bus.msg_valid = (state == SEND);

  // Lanes beyond MAX_BYTES exist only to pad the last word; they never get written.
  genvar i;
  generate
    for (i = 0; i < LANES; i++) begin : g_lane
      if (i < MAX_BYTES) begin : g_used
        assign lane_we[i] = accept && (count == CW'(i));
        cosim_list_msg_lane u_lane (
          .clk (clk),
          .rst (rst),
          .clr (done),
          .we  (lane_we[i]),
          .d   (bus.in_data),
          .q   (lane_q[i])
        );
      end else begin : g_pad
        assign lane_we[i] = 1'b0;
        assign lane_q[i]  = 8'h00;
      end
    end
  endgenerate

  assign list_ptr = {29'(count), 3'd2, 30'd0, 2'b01};
  assign msg      = {lane_q, list_ptr, 64'h0001_0000_0000_0000};
  // Only expose the frame while offered so msg_data reads 0 outside SEND.
  assign bus.msg_data = (state == SEND) ? msg : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      count    <= '0;
      overflow <= 1'b0;
    end else if (state == FILL) begin
      if (accept) begin
        if (count < MAXC) count <= count + 1'b1;
        else              overflow <= 1'b1;
        if (bus.in_last)  state <= SEND;
      end
    end else if (done) begin
      state <= FILL;
      count <= '0;
    end
  end

`ifdef ESI_LIST_ENCODER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)       msg_count <= 32'h0;
    else if (done) msg_count <= msg_count + 32'h1;
  end
`else
  assign msg_count = 32'h0;
`endif
endmodule

// File: doc/cosim_list_msg_encoder.md
Name: cosim_list_msg_encoder

Overview:
- Transmit-side framer for a cosim endpoint's hardware-to-host channel.
- Accepts a byte stream (valid/ready, one byte per beat, last flag) and builds one Cap'n Proto message around it: a root struct pointer, a list-of-bytes pointer, then the byte payload.
- Presents the message on the endpoint's send channel (DataIn side) with a valid/ready handshake.
- Sits between a hardware producer and the Cosim_Endpoint send port. It lets tests originate host-bound traffic instead of only echoing it.

Parameters:
- MAX_BYTES, 3, maximum payload bytes per message; must be ≥1.
- DATA_WORDS, (MAX_BYTES+7)/8, derived localparam: payload words, rounded up to 64-bit multiples.
- MSG_BITS, 128+64*DATA_WORDS, derived localparam: message width; equals the endpoint's SEND_TYPE_SIZE_BITS (192 at default).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  byte beat valid.
- in_ready  out  1  encoder can accept a byte.
- in_data  in  8  payload byte.
- in_last  in  1  beat is the final byte of a message.
- msg_valid  out  1  message available; drives endpoint DataInValid.
- msg_ready  in  1  endpoint DataInReady.
- msg_data  out  MSG_BITS  encoded message; drives endpoint DataIn.
- overflow  out  1  sticky: a message exceeded MAX_BYTES.
- msg_count  out  32  messages sent (see Optional Feature).

Behaviour:
- Reset values:
  - in_ready=0 while rst is high; in_ready=1 in the first cycle after reset.
  - msg_valid=0, msg_data=0, overflow=0, msg_count=0.
  - Internal byte count=0; state=FILL.
- FSM has two states, FILL and SEND.
- FILL:
  - in_ready=1 and msg_valid=0.
  - Accepted byte (in_valid&&in_ready) with count<MAX_BYTES: stored at lane count; count increments.
  - Accepted byte with count==MAX_BYTES: discarded; overflow set (sticky until rst).
  - Accepted byte with in_last=1: the message is frozen on the next edge and state goes to SEND.
- SEND:
  - msg_valid=1 and in_ready=0.
  - msg_data stays stable until msg_valid&&msg_ready.
  - On the handshake: state goes to FILL, count clears, payload lanes clear to 0, msg_count increments.
- Latency and throughput:
  - msg_valid rises in the cycle after the last byte is accepted.
  - At least 1 idle cycle between messages, because in_ready=0 in SEND.
  - Back-to-back throughput is N+1 cycles per N-byte message when msg_ready is held at 1.
- Message layout (little-endian words; word k occupies msg_data[64k+63:64k]):
  - Word0 is the root struct pointer, constant 64'h0001_0000_0000_0000: type 0, offset 0, data words 0, pointer words 1.
  - Word1 is the list pointer:
    - bits[1:0]=2'b01.
    - bits[31:2]=0, so the list follows immediately.
    - bits[34:32]=3'd2, byte elements.
    - bits[63:35]=N, the stored byte count (1..MAX_BYTES).
  - Payload byte i is at msg_data[128+8i +: 8]; unused lanes are 0.
- N is always ≥1, since every beat carries a byte. A message that overflows reports N=MAX_BYTES and keeps its first MAX_BYTES bytes.
- msg_count wraps from 2^32-1 to 0.
- rst asserted mid-FILL or mid-SEND: the partial or pending message is dropped, all outputs return to their reset values, and no message is emitted.
- in_valid is ignored in SEND; no byte is consumed there.

Optional Feature:
- Macro: ESI_LIST_ENCODER_STATS_EN.
- Defined: msg_count is a 32-bit counter of completed send handshakes, as described in Behaviour.
- Undefined: msg_count is tied to 32'h0 and no counter flops are built. All other behaviour is identical.

Test Plan:
- Bytes 0x11,0x22,0x33 (last on 0x33), msg_ready=1 -> msg_valid the cycle after 0x33. Word0=64'h0001000000000000, word1=64'h0000001A00000001, word2=64'h0000000000332211; overflow=0.
- Single byte 0xAB with last -> word1=64'h0000000A00000001, word2=64'h00000000000000AB.
- 3-byte message with msg_ready=0 for 5 cycles -> msg_valid=1 and msg_data constant throughout; in_ready=0; handshake on cycle 6; next cycle in_ready=1.
- 5 bytes 0x01..0x05 (last on 0x05), MAX_BYTES=3 -> word1 count=3, word2=64'h0000000000030201, overflow=1 and still 1 after a following normal message.
- rst pulse after 2 of 3 bytes accepted -> no msg_valid; the next 1-byte message 0x5A reports N=1, word2=0x5A, no stale bytes.
- Two 3-byte messages back-to-back, msg_ready=1, macro defined -> second msg_valid exactly 4 cycles after the first; msg_count=2. With the macro undefined, msg_count stays 0.
